// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator scheduler, motion and display blocks.
package elevator_pkg;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        MOVING,
        DOOR_OPEN
    } sched_state_t;

    localparam int NUM_FLOORS_DEFAULT = 4;
    localparam int FLOOR_W_DEFAULT    = 4;

    localparam logic [FLOOR_W_DEFAULT-1:0] FLOOR_NONE = '0;

endpackage

// File: rtl/elevator_next_floor.sv
// Collective (SCAN) next-floor selection: purely combinational.
// Floors are numbered 1..NUM_FLOORS; pending bit i stands for floor i+1.
module elevator_next_floor
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEFAULT,
    parameter int FLOOR_W    = FLOOR_W_DEFAULT
)(
    input  logic [NUM_FLOORS-1:0] i_pending,
    input  logic [FLOOR_W-1:0]    i_cur_floor,
    input  logic [1:0]            i_dir,
    output logic [FLOOR_W-1:0]    o_next_floor,
    output logic [1:0]            o_next_dir,
    output logic                  o_found
);

    logic [FLOOR_W-1:0] w_above;
    logic [FLOOR_W-1:0] w_below;
    logic [FLOOR_W-1:0] w_dist_up;
    logic [FLOOR_W-1:0] w_dist_dn;
    logic               w_has_above;
    logic               w_has_below;
    logic               w_cur_pending;
    logic               w_cur_valid;
    logic               w_go_up;

    // Nearest pending floor strictly above / strictly below the car.
    always_comb begin
        w_above       = '0;
        w_below       = '0;
        w_has_above   = 1'b0;
        w_has_below   = 1'b0;
        w_cur_pending = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (i_pending[i] && (FLOOR_W'(i + 1) > i_cur_floor)) begin
                w_above     = FLOOR_W'(i + 1);
                w_has_above = 1'b1;
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i_pending[i] && (FLOOR_W'(i + 1) < i_cur_floor)) begin
                w_below     = FLOOR_W'(i + 1);
                w_has_below = 1'b1;
            end
            if (i_pending[i] && (FLOOR_W'(i + 1) == i_cur_floor)) begin
                w_cur_pending = 1'b1;
            end
        end
    end

    assign w_dist_up   = w_above - i_cur_floor;
    assign w_dist_dn   = i_cur_floor - w_below;
    assign w_cur_valid = (i_cur_floor != '0) && (i_cur_floor <= FLOOR_W'(NUM_FLOORS));

    always_comb begin
        w_go_up      = 1'b0;
        o_next_floor = '0;
        o_next_dir   = i_dir;
        o_found      = 1'b0;
        case (i_dir)
            DIR_UP:   w_go_up = w_has_above;
            DIR_DOWN: w_go_up = !w_has_below;
            // Idle: nearest wins, an equal-distance tie goes to the upper floor.
            default:  w_go_up = w_has_above && (!w_has_below || (w_dist_up <= w_dist_dn));
        endcase
        if (w_cur_valid) begin
            if (w_cur_pending) begin
                o_next_floor = i_cur_floor;
                o_found      = 1'b1;
            end else if (w_go_up && w_has_above) begin
                o_next_floor = w_above;
                o_next_dir   = DIR_UP;
                o_found      = 1'b1;
            end else if (w_has_below) begin
                o_next_floor = w_below;
                o_next_dir   = DIR_DOWN;
                o_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Elevator call scheduler: latches floor calls, drives the motion block's target
// with a SCAN policy and times the door-open dwell.
//
// state     | meaning
// IDLE      | no pending calls, car parked
// SELECT    | one cycle to pick the next floor (waits here if cur_floor is invalid)
// MOVING    | target_valid high, car travelling to target_floor
// DOOR_OPEN | dwell timer running, door_open high
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = NUM_FLOORS_DEFAULT,
    parameter int FLOOR_W     = FLOOR_W_DEFAULT,
    parameter int DOOR_CYCLES = 50_000_000
)(
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [NUM_FLOORS-1:0] call_mask,
    input  logic                  call_strobe,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  arrived,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic [1:0]            dir,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    localparam int               CNT_W      = $clog2(DOOR_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DOOR_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_ONE  = CNT_W'(1);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [FLOOR_W-1:0]    r_target;
    dir_t                  r_dir;
    logic [CNT_W-1:0]      r_dwell;

    logic [NUM_FLOORS-1:0] w_cur_onehot;
    logic [NUM_FLOORS-1:0] w_new_calls;
    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [FLOOR_W-1:0]    w_nf_floor;
    logic [1:0]            w_nf_dir;
    logic                  w_nf_found;
    logic [FLOOR_W-1:0]    w_retarget_floor;
    logic                  w_retarget;
    logic                  w_at_target;
    logic                  w_cur_called;
    logic                  w_dwell_done;
    logic                  w_enter_door;
    logic                  w_any_pending;

    elevator_next_floor #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_next_floor (
        .i_pending    (r_pending),
        .i_cur_floor  (cur_floor),
        .i_dir        (r_dir),
        .o_next_floor (w_nf_floor),
        .o_next_dir   (w_nf_dir),
        .o_found      (w_nf_found)
    );

    always_comb begin
        w_cur_onehot = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (cur_floor == FLOOR_W'(i + 1)) begin
                w_cur_onehot[i] = 1'b1;
            end
        end
    end

    assign w_new_calls   = call_strobe ? call_mask : '0;
    assign w_cur_called  = |(w_new_calls & w_cur_onehot);
    assign w_at_target   = arrived && (cur_floor == r_target);
    assign w_dwell_done  = (r_dwell == DWELL_ONE);
    assign w_any_pending = |r_pending;

    // Closest fresh call lying strictly between the car and its target.
    always_comb begin
        w_retarget       = 1'b0;
        w_retarget_floor = r_target;
        if (r_dir == DIR_UP) begin
            for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
                if (w_new_calls[i] && (FLOOR_W'(i + 1) > cur_floor) && (FLOOR_W'(i + 1) < r_target)) begin
                    w_retarget       = 1'b1;
                    w_retarget_floor = FLOOR_W'(i + 1);
                end
            end
        end else if (r_dir == DIR_DOWN) begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (w_new_calls[i] && (FLOOR_W'(i + 1) < cur_floor) && (FLOOR_W'(i + 1) > r_target)) begin
                    w_retarget       = 1'b1;
                    w_retarget_floor = FLOOR_W'(i + 1);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_pending) w_state_nxt = SELECT;
            end
            SELECT: begin
                if (w_nf_found) begin
                    w_state_nxt = (w_nf_floor == cur_floor) ? DOOR_OPEN : MOVING;
                end else if (!w_any_pending) begin
                    w_state_nxt = IDLE;
                end
            end
            MOVING: begin
                if (w_at_target) w_state_nxt = DOOR_OPEN;
            end
            DOOR_OPEN: begin
                if (!w_cur_called && w_dwell_done) begin
                    w_state_nxt = w_any_pending ? SELECT : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_enter_door = (r_state != DOOR_OPEN) && (w_state_nxt == DOOR_OPEN);

    // A call for the floor being served is absorbed by the open door, never latched.
    assign w_set = w_new_calls & ~((r_state == DOOR_OPEN) ? w_cur_onehot : '0);
    assign w_clr = w_enter_door ? w_cur_onehot : '0;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_pending <= '0;
            r_target  <= FLOOR_W'(FLOOR_NONE);
            r_dir     <= DIR_IDLE;
            r_dwell   <= '0;
        end else begin
            r_pending <= (r_pending | w_set) & ~w_clr;

            if ((r_state == SELECT) && w_nf_found) begin
                r_dir <= dir_t'(w_nf_dir);
            end else if ((r_state == DOOR_OPEN) && (w_state_nxt == IDLE)) begin
                r_dir <= DIR_IDLE;
            end

            if ((r_state == SELECT) && (w_state_nxt == MOVING)) begin
                r_target <= w_nf_floor;
            end else if ((r_state == MOVING) && !w_at_target && w_retarget) begin
                r_target <= w_retarget_floor;
            end

            if (w_enter_door) begin
                r_dwell <= DWELL_LOAD;
            end else if (r_state == DOOR_OPEN) begin
                if (w_cur_called) begin
                    r_dwell <= DWELL_LOAD;
                end else if (w_dwell_done) begin
                    r_dwell <= '0;
                end else begin
                    r_dwell <= r_dwell - DWELL_ONE;
                end
            end
        end
    end

    assign target_floor = r_target;
    assign target_valid = (r_state == MOVING);
    assign dir          = r_dir;
    assign door_open    = (r_state == DOOR_OPEN);
    assign pending      = r_pending;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: directed scenarios plus random calls,
// all checked against a behavioural model of the scheduling rules.
module tb_elevator_request_scheduler;
    import elevator_pkg::*;

    localparam int NF = 4;
    localparam int FW = 4;
    localparam int DC = 4;

    localparam int PH_IDLE   = 0;
    localparam int PH_SELECT = 1;
    localparam int PH_MOVE   = 2;
    localparam int PH_DOOR   = 3;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic [NF-1:0] call_mask = '0;
    logic          call_strobe = 1'b0;
    logic [FW-1:0] cur_floor = FW'(1);
    logic          arrived = 1'b0;
    logic [FW-1:0] target_floor;
    logic          target_valid;
    logic [1:0]    dir;
    logic          door_open;
    logic [NF-1:0] pending;
    logic          busy;

    elevator_request_scheduler #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .DOOR_CYCLES (DC)
    ) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .call_mask    (call_mask),
        .call_strobe  (call_strobe),
        .cur_floor    (cur_floor),
        .arrived      (arrived),
        .target_floor (target_floor),
        .target_valid (target_valid),
        .dir          (dir),
        .door_open    (door_open),
        .pending      (pending),
        .busy         (busy)
    );

    always #5 iCLK = ~iCLK;

    int n_tests = 0;
    int n_fail  = 0;
    int door_cnt = 0;

    // reference model: calls indexed by floor number
    bit [NF:1] m_pend;
    int        m_phase;
    int        m_target;
    int        m_dir;
    int        m_open;

    // motion stub
    int tb_cur = 1;
    int step_cnt = 0;
    bit rand_arrive = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void pick(input bit [NF:1] p, input int cur, input int d,
                                 output bit found, output int fl, output int nd);
        int up_f;
        int dn_f;
        found = 1'b0;
        fl    = 0;
        nd    = d;
        up_f  = 0;
        dn_f  = 0;
        if (cur < 1 || cur > NF) return;
        if (p[cur]) begin
            found = 1'b1;
            fl    = cur;
            return;
        end
        for (int f = 1; f <= NF; f++) begin
            if (p[f] && f > cur && (up_f == 0 || (f - cur) < (up_f - cur))) up_f = f;
            if (p[f] && f < cur && (dn_f == 0 || (cur - f) < (cur - dn_f))) dn_f = f;
        end
        if (d == 1) begin
            if (up_f != 0)      begin fl = up_f; nd = 1; end
            else if (dn_f != 0) begin fl = dn_f; nd = 2; end
        end else if (d == 2) begin
            if (dn_f != 0)      begin fl = dn_f; nd = 2; end
            else if (up_f != 0) begin fl = up_f; nd = 1; end
        end else begin
            if (up_f != 0 && (dn_f == 0 || (up_f - cur) <= (cur - dn_f))) begin fl = up_f; nd = 1; end
            else if (dn_f != 0) begin fl = dn_f; nd = 2; end
        end
        found = (fl != 0);
    endfunction

    task automatic model_reset();
        m_pend   = '0;
        m_phase  = PH_IDLE;
        m_target = 0;
        m_dir    = 0;
        m_open   = 0;
    endtask

    task automatic model_step(input bit stb, input bit [NF:1] msk, input int cur, input bit arr);
        bit [NF:1] newc;
        bit        was_empty;
        bit        in_door;
        bit        clear_cur;
        bit        found;
        int        fl;
        int        nd;
        int        best;
        newc      = stb ? msk : '0;
        was_empty = (m_pend == '0);
        in_door   = (m_phase == PH_DOOR);
        clear_cur = 1'b0;
        case (m_phase)
            PH_IDLE: if (!was_empty) m_phase = PH_SELECT;
            PH_SELECT: begin
                pick(m_pend, cur, m_dir, found, fl, nd);
                if (found) begin
                    m_dir = nd;
                    if (fl == cur) begin
                        m_phase   = PH_DOOR;
                        m_open    = 1;
                        clear_cur = 1'b1;
                    end else begin
                        m_phase  = PH_MOVE;
                        m_target = fl;
                    end
                end else if (was_empty) begin
                    m_phase = PH_IDLE;
                end
            end
            PH_MOVE: begin
                if (arr && cur == m_target) begin
                    m_phase   = PH_DOOR;
                    m_open    = 1;
                    clear_cur = 1'b1;
                end else begin
                    best = 0;
                    for (int f = 1; f <= NF; f++) begin
                        if (newc[f] && ((m_dir == 1 && f > cur && f < m_target) ||
                                        (m_dir == 2 && f < cur && f > m_target))) begin
                            if (best == 0 || (f > cur ? f - cur : cur - f) < (best > cur ? best - cur : cur - best))
                                best = f;
                        end
                    end
                    if (best != 0) m_target = best;
                end
            end
            default: begin
                if (cur >= 1 && cur <= NF && newc[cur]) begin
                    m_open = 1;
                end else if (m_open == DC) begin
                    if (was_empty) begin
                        m_phase = PH_IDLE;
                        m_dir   = 0;
                    end else begin
                        m_phase = PH_SELECT;
                    end
                end else begin
                    m_open++;
                end
            end
        endcase
        for (int f = 1; f <= NF; f++) begin
            if (newc[f] && !(f == cur && (in_door || clear_cur))) m_pend[f] = 1'b1;
            if (clear_cur && f == cur) m_pend[f] = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("pending",      int'(pending),      int'(m_pend));
        check("target_floor", int'(target_floor), m_target);
        check("target_valid", int'(target_valid), int'(m_phase == PH_MOVE));
        check("dir",          int'(dir),          m_dir);
        check("door_open",    int'(door_open),    int'(m_phase == PH_DOOR));
        check("busy",         int'(busy),         int'(m_phase != PH_IDLE));
    endtask

    // One clock: motion stub + stimulus, edge, model update, check.
    task automatic tick(input bit stb, input bit [NF:1] msk, input bit on_arrive);
        bit arr;
        arr = 1'b0;
        if (target_valid) begin
            if (tb_cur == int'(target_floor)) begin
                arr = 1'b1;
            end else begin
                step_cnt++;
                if (step_cnt == 3) begin
                    step_cnt = 0;
                    tb_cur   = (int'(target_floor) > tb_cur) ? tb_cur + 1 : tb_cur - 1;
                end
            end
        end else begin
            step_cnt = 0;
        end
        if (rand_arrive && !arr && $urandom_range(0, 19) == 0) arr = 1'b1;
        if (on_arrive && !arr) stb = 1'b0;
        cur_floor   = FW'(tb_cur);
        arrived     = arr;
        call_strobe = stb;
        call_mask   = msk;
        @(posedge iCLK);
        model_step(stb, msk, tb_cur, arr);
        @(negedge iCLK);
        compare_all();
        if (door_open) door_cnt++;
    endtask

    function automatic bit cond_met(input int what);
        case (what)
            0:       return door_open;
            1:       return target_valid;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_for(input int what, input int max_cycles);
        int n;
        n = 0;
        while (!cond_met(what) && n < max_cycles) begin
            tick(1'b0, '0, 1'b0);
            n++;
        end
        check($sformatf("wait_cond%0d", what), int'(cond_met(what)), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge iCLK);
        compare_all();
        iRST = 1'b0;

        // single call from floor 1 to floor 3
        tb_cur = 1;
        tick(1'b1, 4'b0100, 1'b0);
        check("s1_pending", int'(pending), 4);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        check("s1_target", int'(target_floor), 3);
        check("s1_valid",  int'(target_valid), 1);
        check("s1_dir",    int'(dir), int'(DIR_UP));
        door_cnt = 0;
        wait_for(2, 100);
        check("s1_dwell",   door_cnt, DC);
        check("s1_pend0",   int'(pending), 0);
        check("s1_dir_idle", int'(dir), int'(DIR_IDLE));

        // retarget to 2 while heading for 4
        tb_cur = 1;
        tick(1'b1, 4'b1000, 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        check("s2_target4", int'(target_floor), 4);
        tick(1'b1, 4'b0010, 1'b0);
        check("s2_retarget", int'(target_floor), 2);
        check("s2_valid",    int'(target_valid), 1);
        wait_for(0, 100);
        wait_for(1, 100);
        check("s2_resume", int'(target_floor), 4);
        check("s2_dir",    int'(dir), int'(DIR_UP));
        wait_for(2, 200);

        // at 2 heading up with {1,4} pending
        tb_cur = 1;
        tick(1'b1, 4'b0010, 1'b0);
        wait_for(0, 100);
        tick(1'b1, 4'b1001, 1'b0);
        wait_for(1, 100);
        check("s3_first", int'(target_floor), 4);
        check("s3_dir_up", int'(dir), int'(DIR_UP));
        wait_for(0, 100);
        wait_for(1, 100);
        check("s3_second", int'(target_floor), 1);
        check("s3_dir_dn", int'(dir), int'(DIR_DOWN));
        wait_for(2, 300);

        // tie at 2 with {1,3}, then dwell restart at 2
        tb_cur = 2;
        tick(1'b1, 4'b0101, 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        check("s4_tie",    int'(target_floor), 3);
        check("s4_tie_dir", int'(dir), int'(DIR_UP));
        wait_for(2, 300);
        tb_cur = 2;
        door_cnt = 0;
        tick(1'b1, 4'b0010, 1'b0);
        wait_for(0, 20);
        tick(1'b1, 4'b0010, 1'b0);
        wait_for(2, 50);
        check("s4_restart_dwell", door_cnt, DC + 1);
        check("s4_pend0", int'(pending), 0);

        // asynchronous reset while moving
        tb_cur = 1;
        tick(1'b1, 4'b1010, 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        check("s5_pend",  int'(pending), 10);
        check("s5_valid", int'(target_valid), 1);
        #2 iRST = 1'b1;
        #1;
        check("s5_rst_valid",  int'(target_valid), 0);
        check("s5_rst_target", int'(target_floor), 0);
        check("s5_rst_pend",   int'(pending), 0);
        check("s5_rst_dir",    int'(dir), 0);
        check("s5_rst_door",   int'(door_open), 0);
        check("s5_rst_busy",   int'(busy), 0);
        model_reset();
        @(negedge iCLK);
        iRST = 1'b0;
        repeat (6) tick(1'b0, '0, 1'b0);
        check("s5_no_target", int'(target_valid), 0);

        // arrival at 3 with a same-cycle call for 3
        tb_cur = 1;
        tick(1'b1, 4'b0100, 1'b0);
        door_cnt = 0;
        for (int i = 0; i < 100 && !door_open; i++) tick(1'b1, 4'b0100, 1'b1);
        check("s6_bit3_clear", int'(pending[2]), 0);
        wait_for(2, 50);
        check("s6_single_dwell", door_cnt, DC);
        check("s6_pend0", int'(pending), 0);

        // invalid cur_floor holds SELECT without a target
        tb_cur = 0;
        tick(1'b1, 4'b0001, 1'b0);
        repeat (3) tick(1'b0, '0, 1'b0);
        check("s7_busy",  int'(busy), 1);
        check("s7_valid", int'(target_valid), 0);
        tb_cur = 1;
        wait_for(2, 50);
        check("s7_pend0", int'(pending), 0);

        // random traffic
        rand_arrive = 1'b1;
        repeat (1500) tick(($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)), 1'b0);
        rand_arrive = 1'b0;
        wait_for(2, 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Collects floor calls from the car and hall switches, holds them as a pending set, and picks the next target floor using a collective (SCAN) policy. It sits between the call-input logic and the elevator motion/floor-counter block. It issues `target_floor`/`target_valid` to that block and consumes its `cur_floor`/`arrived` feedback. It also times the door-open dwell and publishes direction and pending state for the seven-segment/LCD displays.

## Interface
Parameters:
- `NUM_FLOORS`, 4: number of served floors, numbered 1..NUM_FLOORS.
- `FLOOR_W`, 4: width of floor-number buses; encoding 0 means "none".
- `DOOR_CYCLES`, 50_000_000: door-open dwell in iCLK cycles (1 s at 50 MHz).

Ports:
- `iCLK` in 1: single clock; all state on rising edge.
- `iRST` in 1: reset, asynchronous, active-high.
- `call_mask` in NUM_FLOORS: bit i requests floor i+1; sampled only with `call_strobe`.
- `call_strobe` in 1: one-cycle, already synchronized/debounced pulse.
- `cur_floor` in FLOOR_W: current floor from the motion block.
- `arrived` in 1: one-cycle pulse when the car has stopped at `cur_floor`.
- `target_floor` out FLOOR_W: floor the motion block must travel to.
- `target_valid` out 1: target is live; motion block moves only while high.
- `dir` out 2: dir_t, the current travel direction.
- `door_open` out 1: high during dwell.
- `pending` out NUM_FLOORS: registered pending-call set.
- `busy` out 1: state != IDLE.

## Operation
- Reset values:
  - state IDLE, `pending` 0, `target_floor` 0, `target_valid` 0.
  - `dir` DIR_IDLE, `door_open` 0, `busy` 0, dwell counter 0.
- Call capture:
  - Each iCLK edge with `call_strobe` ORs `call_mask` into `pending`.
  - Multiple bits are all accepted, with no priority.
  - A zero mask is a no-op.
- Arrival clearing:
  - The pending bit for `cur_floor` is cleared on entry to DOOR_OPEN.
  - Clear wins over a same-cycle set for the same floor.
- State machine:
  - **IDLE**: `pending` != 0 → SELECT.
  - **SELECT** (one cycle): compute the next floor by the selection rule.
    - Chosen == `cur_floor` → DOOR_OPEN.
    - Otherwise → MOVING: load `target_floor`, assert `target_valid`, set `dir`.
    - `cur_floor` outside 1..NUM_FLOORS → stay in SELECT, no target.
  - **MOVING**:
    - A newly pending floor strictly between `cur_floor` and `target_floor` in the travel direction replaces `target_floor` next cycle; `target_valid` stays high.
    - `arrived` with `cur_floor == target_floor` → DOOR_OPEN, drop `target_valid`.
    - `arrived` with any other floor is ignored.
  - **DOOR_OPEN**: `door_open`=1 and the counter runs DOOR_CYCLES cycles.
    - A call for `cur_floor` during dwell restarts the counter and is not latched into `pending`.
    - At expiry: `pending` == 0 → IDLE with `dir` = DIR_IDLE; else → SELECT.
- Selection rule, with above/below meaning pending floors strictly above/below `cur_floor`:
  - `dir` UP: nearest floor above if any; else nearest below, `dir` → DOWN.
  - `dir` DOWN: the mirror of UP.
  - `dir` IDLE: nearest pending floor; on an equal-distance tie, pick the upper one.
  - `cur_floor` itself pending → serve it first.
- Arithmetic: floor distances are unsigned FLOOR_W; floors 1..NUM_FLOORS never wrap. The dwell counter is $clog2(DOOR_CYCLES+1) bits.
- Reset mid-operation clears everything immediately, including `target_valid`. The motion block must stop on `target_valid`=0.

## Timing
- `call_strobe` at edge N → `pending` bit visible after N.
- From IDLE: SELECT at N+1, `target_valid` high after N+2, so the first target is 2 cycles after the strobe.
- Retarget in MOVING: 1 cycle after the call strobe edge.
- `arrived` at edge A → `target_valid` low and `door_open` high after A; the bit is cleared at A.
- `door_open` is high for exactly DOOR_CYCLES cycles, then SELECT or IDLE on the next edge.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package `elevator_pkg`:
  - `dir_t` (DIR_IDLE=2'd0, DIR_UP=2'd1, DIR_DOWN=2'd2).
  - `sched_state_t` (IDLE, SELECT, MOVING, DOOR_OPEN).
  - `FLOOR_NONE`=0 and the default NUM_FLOORS/FLOOR_W.
  - This package is shared with the motion and display blocks.
- One sub-module, `elevator_next_floor`: combinational selection rule. Inputs are pending, cur_floor and dir; outputs are next floor, next dir and found. It is tested standalone.

## Test plan
Bench uses DOOR_CYCLES=4, cur_floor modelled by a stub that steps 1 floor per 3 cycles and pulses `arrived` at target.
- Reset then idle at floor 1, strobe mask 4'b0100 → `target_floor`=3 two cycles later, `dir`=UP; `arrived` at 3 → `door_open` 4 cycles → IDLE, `pending`=0, `dir`=IDLE.
- Moving up to 4 from floor 1, mask 4'b0010 strobed while `cur_floor`=1 → `target_floor` changes to 2; after dwell, target 4 resumes with `dir`=UP.
- At floor 2 heading UP, pending {1,4} → selects 4 first, then 1 with `dir`=DOWN.
- Idle at floor 2, pending {1,3} tie → selects 3; strobe mask 4'b0010 during dwell at 2 restarts the counter, giving 4+ cycles of `door_open`.
- `iRST` asserted mid-MOVING with pending 4'b1010 → all outputs return to reset values asynchronously; no target after release until a new strobe arrives.
- Simultaneous `arrived` at 3 and strobe 4'b0100 → bit 3 stays clear, single dwell.
